// File: rtl/frac_div_pkg.sv
// frac_div_pkg
// Shared definitions for the fractional-N divider controller:
//   - SDM_W        : width of the signed sigma-delta output (-3..+4)
//   - order_e      : modulator order encodings (integer-only, MASH-1, 1-1, 1-1-1)
//   - DIV_RST_DEF  : default modulus loaded at reset
//   - DIV_MIN_DEF  : default modulus saturation floor
//   - clamp_mod()  : saturates a signed modulus request into [lo, hi]
package frac_div_pkg;

  localparam int SDM_W       = 4;
  localparam int DIV_RST_DEF = 30;
  localparam int DIV_MIN_DEF = 4;

  typedef enum logic [1:0] {
    ORD_INT = 2'd0,
    ORD1    = 2'd1,
    ORD2    = 2'd2,
    ORD3    = 2'd3
  } order_e;

  // Saturate a requested modulus into the range the counter can realise.
  function automatic int clamp_mod(input int m, input int lo, input int hi);
    if (m < lo) return lo;
    else if (m > hi) return hi;
    else return m;
  endfunction

endpackage

// File: rtl/sdm_mash111.sv
// sdm_mash111
// MASH 1-1-1 sigma-delta modulator with run-time order selection (1..MAX_ORD).
// Advances one step per 'step' strobe; stages above the selected order are held at 0.
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous reset, active-high
//   step   in   1      advance the modulator by one step (divider tick)
//   clr    in   1      at a step: clear accumulators, delay taps and output instead of stepping
//   order  in   2      effective order (already clamped to MAX_ORD by the caller)
//   frac   in   FW     fractional input word
//   y      out  4      registered signed noise-cancelled output (-3..+4)
module sdm_mash111
  import frac_div_pkg::*;
#(
  parameter int FW      = 16,
  parameter int MAX_ORD = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          clr,
  input  logic [1:0]    order,
  input  logic [FW-1:0] frac,
  output logic [SDM_W-1:0] y
);

  logic [FW-1:0] acc1, acc2, acc3;
  logic          c2_d, c3_d, c3_dd;
  logic [FW:0]   s1, s2, s3;
  logic          use2, use3;
  logic signed [SDM_W-1:0] t1, t2, t3, y_nxt;

  // Cascade of accumulators; each stage integrates the residue of the one
  // before it. The carry bits feed the noise-cancellation network, where the
  // second stage is differentiated once and the third twice.
  always_comb begin
    use2  = (MAX_ORD >= 2) && (order >= 2'd2);
    use3  = (MAX_ORD >= 3) && (order == 2'd3);
    s1    = {1'b0, acc1} + {1'b0, frac};
    s2    = use2 ? ({1'b0, acc2} + {1'b0, s1[FW-1:0]}) : '0;
    s3    = use3 ? ({1'b0, acc3} + {1'b0, s2[FW-1:0]}) : '0;
    t1    = {3'b000, s1[FW]};
    t2    = use2 ? ($signed({3'b000, s2[FW]}) - $signed({3'b000, c2_d})) : 4'sd0;
    t3    = use3 ? ($signed({3'b000, s3[FW]}) - $signed({2'b00, c3_d, 1'b0})
                    + $signed({3'b000, c3_dd})) : 4'sd0;
    y_nxt = t1 + t2 + t3;
  end

  // State only moves on a step; a clear at a step restarts the modulator
  // from all-zero so a new order or re-enable begins from a known state.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc1  <= '0;
      acc2  <= '0;
      acc3  <= '0;
      c2_d  <= 1'b0;
      c3_d  <= 1'b0;
      c3_dd <= 1'b0;
      y     <= '0;
    end else if (step) begin
      if (clr) begin
        acc1  <= '0;
        acc2  <= '0;
        acc3  <= '0;
        c2_d  <= 1'b0;
        c3_d  <= 1'b0;
        c3_dd <= 1'b0;
        y     <= '0;
      end else begin
        acc1  <= s1[FW-1:0];
        acc2  <= s2[FW-1:0];
        acc3  <= s3[FW-1:0];
        c2_d  <= s2[FW];
        c3_dd <= c3_d;
        c3_d  <= s3[FW];
        y     <= y_nxt;
      end
    end
  end

endmodule

// File: rtl/frac_n_div_ctrl.sv
// frac_n_div_ctrl
// Fractional-N loop-divider controller: a programmable down-counter whose modulus
// is n_int dithered by an in-line MASH sigma-delta modulator, with saturation of
// the modulus into [DIV_MIN, 2^NW-1].
// Ports:
//   clk        in   1    divider input clock, rising edge
//   rst        in   1    synchronous reset, active-high
//   n_int      in   NW   integer part of the division ratio
//   frac       in   FW   fractional part of the division ratio
//   sdm_en     in   1    1 = modulator active, 0 = integer-N
//   order_sel  in   2    0 integer-only, 1/2/3 MASH-1 / 1-1 / 1-1-1
//   div_clk_o  out  1    divided clock, high floor(div_ctrl/2) cycles per period
//   div_pulse  out  1    strobe in the last cycle of each period
//   div_ctrl   out  NW   modulus of the current period
//   sdm_q      out  4    signed SDM output applied at the next tick
//   sat_o      out  1    the current period's modulus was clamped
module frac_n_div_ctrl
  import frac_div_pkg::*;
#(
  parameter int NW      = 6,
  parameter int FW      = 16,
  parameter int MAX_ORD = 3,
  parameter int DIV_RST = DIV_RST_DEF,
  parameter int DIV_MIN = DIV_MIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    n_int,
  input  logic [FW-1:0]    frac,
  input  logic             sdm_en,
  input  logic [1:0]       order_sel,
  output logic             div_clk_o,
  output logic             div_pulse,
  output logic [NW-1:0]    div_ctrl,
  output logic [SDM_W-1:0] sdm_q,
  output logic             sat_o
);

  localparam int DIV_MAX = (1 << NW) - 1;

  logic [NW-1:0]          cnt, cnt_nxt, ctrl_nxt;
  logic [NW:0]            half_nxt;
  logic                   tick, sdm_clr, clk_nxt;
  order_e                 ord_eff, ord_q;
  logic signed [NW+1:0]   m_ext;
  int                     m_int, m_clamp;

  // Tick decode, order clamping and the next modulus. The modulus uses the
  // registered sdm_q, which is what gives the one-period SDM pipeline. The
  // modulator restarts whenever it is disabled, integer-only, or the order
  // differs from the one in force at the previous tick.
  always_comb begin
    tick     = (cnt == '0);
    ord_eff  = (order_sel > 2'(MAX_ORD)) ? order_e'(2'(MAX_ORD)) : order_e'(order_sel);
    sdm_clr  = !sdm_en || (ord_eff == ORD_INT) || (ord_eff != ord_q);
    m_ext    = $signed({2'b00, n_int}) + $signed({{(NW-2){sdm_q[SDM_W-1]}}, sdm_q});
    m_int    = int'(m_ext);
    m_clamp  = clamp_mod(m_int, DIV_MIN, DIV_MAX);
    if (tick) begin
      ctrl_nxt = NW'(m_clamp);
      cnt_nxt  = NW'(m_clamp - 1);
    end else begin
      ctrl_nxt = div_ctrl;
      cnt_nxt  = cnt - 1'b1;
    end
    // High while the count is in the upper floor(n/2) states of the period.
    half_nxt = ({1'b0, ctrl_nxt} + (NW+1)'(1)) >> 1;
    clk_nxt  = ({1'b0, cnt_nxt} >= half_nxt);
  end

  // Counter and registered outputs. Pulse and divided clock are computed from
  // the next count so they line up with the count they describe. Modulus,
  // saturation flag and latched order only change at a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= NW'(DIV_RST - 1);
      div_ctrl  <= NW'(DIV_RST);
      div_pulse <= 1'b0;
      div_clk_o <= 1'b0;
      sat_o     <= 1'b0;
      ord_q     <= ORD_INT;
    end else begin
      cnt       <= cnt_nxt;
      div_ctrl  <= ctrl_nxt;
      div_pulse <= (cnt_nxt == '0);
      div_clk_o <= clk_nxt;
      if (tick) begin
        sat_o <= (m_int != m_clamp);
        ord_q <= ord_eff;
      end
    end
  end

  sdm_mash111 #(
    .FW      (FW),
    .MAX_ORD (MAX_ORD)
  ) u_sdm (
    .clk   (clk),
    .rst   (rst),
    .step  (tick),
    .clr   (sdm_clr),
    .order (ord_eff),
    .frac  (frac),
    .y     (sdm_q)
  );

endmodule
